// File: rtl/button_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce, press/release pulses, optional auto-repeat.
// Define BTN_AUTOREPEAT_EN to build the per-channel repeat FSMs behind btn_event/btn_hold.
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_event,
    output logic [N_BTN-1:0] btn_hold,
    output logic             any_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
            $error("button_conditioner: timing parameters must all be >= 1");
        end
    endgenerate

    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s2;
    logic [CW-1:0]    r_cnt [N_BTN];
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic [N_BTN-1:0] r_event;
    logic             r_any;

    logic [N_BTN-1:0] w_change;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_fall;

    // A level change is accepted once the synchronised input has disagreed for DEBOUNCE_CYCLES edges.
    always_comb begin
        w_change = '0;
        w_rise   = '0;
        w_fall   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_change[i] = (r_s2[i] != r_level[i]) && (r_cnt[i] == DB_LAST);
            w_rise[i]   = w_change[i] && r_s2[i];
            w_fall[i]   = w_change[i] && !r_s2[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_any     <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1      <= btn_raw;
            r_s2      <= r_s1;
            r_level   <= r_level ^ w_change;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_any     <= |w_rise;
            for (int i = 0; i < N_BTN; i++) begin
                if ((r_s2[i] == r_level[i]) || w_change[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [1:0]       r_state [N_BTN];
    logic [TW-1:0]    r_timer [N_BTN];
    logic [N_BTN-1:0] r_hold;

    // A debounced fall always returns to IDLE and suppresses any timer expiry on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_event <= '0;
            r_hold  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= ST_IDLE;
                r_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                r_event[i] <= 1'b0;
                if (w_fall[i]) begin
                    r_state[i] <= ST_IDLE;
                    r_timer[i] <= '0;
                    r_hold[i]  <= 1'b0;
                end else begin
                    case (r_state[i])
                        ST_IDLE: begin
                            if (w_rise[i]) begin
                                r_state[i] <= ST_DELAY;
                                r_timer[i] <= '0;
                                r_event[i] <= 1'b1;
                            end
                        end
                        ST_DELAY: begin
                            if (r_timer[i] == RD_LAST) begin
                                r_state[i] <= ST_REPEAT;
                                r_timer[i] <= '0;
                                r_event[i] <= 1'b1;
                                r_hold[i]  <= 1'b1;
                            end else begin
                                r_timer[i] <= r_timer[i] + TW'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (r_timer[i] == RP_LAST) begin
                                r_timer[i] <= '0;
                                r_event[i] <= 1'b1;
                            end else begin
                                r_timer[i] <= r_timer[i] + TW'(1);
                            end
                        end
                        default: begin
                            r_state[i] <= ST_IDLE;
                            r_timer[i] <= '0;
                            r_hold[i]  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign btn_hold = r_hold;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_event <= '0;
        end else begin
            r_event <= w_rise;
        end
    end

    assign btn_hold = '0;
`endif

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_event   = r_event;
    assign any_press   = r_any;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed literal checks plus randomized buttons against a
// window-based reference model; follows BTN_AUTOREPEAT_EN the same way the design does.
module tb_button_conditioner;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;
`ifdef BTN_AUTOREPEAT_EN
    localparam logic AR = 1'b1;
`else
    localparam logic AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_event;
    logic [N-1:0] btn_hold;
    logic         any_press;

    int compared   = 0;
    int mismatched = 0;
    bit compareOn  = 0;

    button_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_event(btn_event), .btn_hold(btn_hold), .any_press(any_press)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips once the last D synchronised samples all disagree with it;
    // repeat events are pure arithmetic on the distance from the press edge.
    logic [N-1:0] mLevel, mPress, mRelease, mEvent, mHold;
    logic         mAny;
    bit           d1 [N];
    bit           d2 [N];
    bit           hq [N][$];
    int           pressEdge [N];
    int           cyc = 0;

    function automatic bit windowAll(int ch, bit v);
        if (hq[ch].size() != D) return 1'b0;
        for (int j = 0; j < hq[ch].size(); j++) begin
            if (hq[ch][j] != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        bit seen, rise, fall;
        int dt;
        cyc++;
        if (rst) begin
            mLevel = '0; mPress = '0; mRelease = '0; mEvent = '0; mHold = '0; mAny = 1'b0;
            for (int ch = 0; ch < N; ch++) begin
                d1[ch] = 0; d2[ch] = 0; hq[ch].delete(); pressEdge[ch] = -1;
            end
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                seen = d2[ch];
                d2[ch] = d1[ch];
                d1[ch] = btn_raw[ch];
                hq[ch].push_back(seen);
                if (hq[ch].size() > D) void'(hq[ch].pop_front());
                rise = !mLevel[ch] && windowAll(ch, 1'b1);
                fall = mLevel[ch] && windowAll(ch, 1'b0);
                if (rise || fall) hq[ch].delete();
                mPress[ch]   = rise;
                mRelease[ch] = fall;
                if (rise) mLevel[ch] = 1'b1;
                if (fall) mLevel[ch] = 1'b0;
                if (rise) pressEdge[ch] = cyc;
                if (fall) pressEdge[ch] = -1;
                if (AR) begin
                    dt = (pressEdge[ch] >= 0) ? (cyc - pressEdge[ch]) : -1;
                    mEvent[ch] = rise || (dt == RD) || ((dt > RD) && ((dt - RD) % RP == 0));
                    mHold[ch]  = (dt >= RD);
                end else begin
                    mEvent[ch] = rise;
                    mHold[ch]  = 1'b0;
                end
            end
            mAny = |mPress;
        end
    end

    task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] raw, input logic rstVal, input int cycles);
        btn_raw = raw;
        rst     = rstVal;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin : compare
        forever begin
            @(posedge clk);
            #1;
            if (compareOn) begin
                checkOutput("model level",   btn_level,   mLevel);
                checkOutput("model press",   btn_press,   mPress);
                checkOutput("model release", btn_release, mRelease);
                checkOutput("model event",   btn_event,   mEvent);
                checkOutput("model hold",    btn_hold,    mHold);
                checkOutput("model any",     {{(N-1){1'b0}}, any_press}, {{(N-1){1'b0}}, mAny});
            end
        end
    end

    initial begin : stimulus
        int remaining [N];
        logic [N-1:0] raw;
        compareOn = 1;
        applyStimulus('0, 1'b1, 3);
        checkOutput("reset level", btn_level, '0);
        checkOutput("reset event", btn_event, '0);
        checkOutput("reset any",   {{(N-1){1'b0}}, any_press}, '0);

        // Single press: accepted after edge k+5 only.
        applyStimulus(5'b00001, 1'b0, 5);
        checkOutput("t1 level early", btn_level, 5'b00000);
        checkOutput("t1 press early", btn_press, 5'b00000);
        applyStimulus(5'b00001, 1'b0, 1);
        checkOutput("t1 level", btn_level, 5'b00001);
        checkOutput("t1 press", btn_press, 5'b00001);
        checkOutput("t1 any",   {{(N-1){1'b0}}, any_press}, 5'b00001);
        applyStimulus(5'b00001, 1'b0, 1);
        checkOutput("t1 press single", btn_press, 5'b00000);
        applyStimulus('0, 1'b0, 12);
        checkOutput("t1 released", btn_level, 5'b00000);

        // Short glitch is ignored; a D-cycle pulse presses and releases.
        applyStimulus(5'b00010, 1'b0, 3);
        for (int i = 0; i < 8; i++) begin
            applyStimulus('0, 1'b0, 1);
            checkOutput("t2 glitch level", btn_level, 5'b00000);
        end
        applyStimulus(5'b00010, 1'b0, 4);
        applyStimulus('0, 1'b0, 2);
        checkOutput("t2 pulse level", btn_level, 5'b00010);
        checkOutput("t2 pulse press", btn_press, 5'b00010);
        applyStimulus('0, 1'b0, 3);
        checkOutput("t2 still level",  btn_level,   5'b00010);
        checkOutput("t2 no release",   btn_release, 5'b00000);
        applyStimulus('0, 1'b0, 1);
        checkOutput("t2 release",      btn_release, 5'b00010);
        checkOutput("t2 level fallen", btn_level,   5'b00000);

        // Hold channel 2; release lands on the edge of the second REPEAT expiry.
        applyStimulus(5'b00100, 1'b0, 6);
        checkOutput("t3 event P",   btn_event, 5'b00100);
        applyStimulus(5'b00100, 1'b0, 1);
        checkOutput("t3 event P+1", btn_event, 5'b00000);
        applyStimulus(5'b00100, 1'b0, 8);
        checkOutput("t3 hold P+9",  btn_hold,  5'b00000);
        applyStimulus(5'b00100, 1'b0, 1);
        checkOutput("t3 event P+10", btn_event, AR ? 5'b00100 : 5'b00000);
        checkOutput("t3 hold P+10",  btn_hold,  AR ? 5'b00100 : 5'b00000);
        applyStimulus(5'b00100, 1'b0, 4);
        applyStimulus('0, 1'b0, 1);
        checkOutput("t3 event P+15", btn_event, AR ? 5'b00100 : 5'b00000);
        applyStimulus('0, 1'b0, 4);
        checkOutput("t4 level P+19", btn_level, 5'b00100);
        applyStimulus('0, 1'b0, 1);
        checkOutput("t4 no event on release", btn_event,   5'b00000);
        checkOutput("t4 release",             btn_release, 5'b00100);
        checkOutput("t4 hold cleared",        btn_hold,    5'b00000);
        applyStimulus('0, 1'b0, 6);

        // Simultaneous presses on channels 3 and 4.
        applyStimulus(5'b11000, 1'b0, 6);
        checkOutput("t5 press", btn_press, 5'b11000);
        checkOutput("t5 any",   {{(N-1){1'b0}}, any_press}, 5'b00001);
        applyStimulus(5'b11000, 1'b0, 1);
        checkOutput("t5 any single", {{(N-1){1'b0}}, any_press}, 5'b00000);
        applyStimulus('0, 1'b0, 12);

        // Reset while channel 0 is held in REPEAT, then a fresh press.
        applyStimulus(5'b00001, 1'b0, 18);
        checkOutput("t6 hold before rst", btn_hold, AR ? 5'b00001 : 5'b00000);
        applyStimulus(5'b00001, 1'b1, 1);
        checkOutput("t6 rst level",   btn_level,   5'b00000);
        checkOutput("t6 rst release", btn_release, 5'b00000);
        checkOutput("t6 rst hold",    btn_hold,    5'b00000);
        applyStimulus(5'b00001, 1'b1, 1);
        applyStimulus(5'b00001, 1'b0, 5);
        checkOutput("t6 no press yet", btn_press, 5'b00000);
        applyStimulus(5'b00001, 1'b0, 1);
        checkOutput("t6 fresh press", btn_press, 5'b00001);
        checkOutput("t6 fresh event", btn_event, 5'b00001);
        applyStimulus('0, 1'b0, 12);

        // Randomized buttons with random hold lengths and occasional resets.
        raw = '0;
        for (int ch = 0; ch < N; ch++) remaining[ch] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (remaining[ch] == 0) begin
                    raw[ch] = ~raw[ch];
                    remaining[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                               : $urandom_range(1, 40);
                end else begin
                    remaining[ch]--;
                end
            end
            applyStimulus(raw, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, 1);
        end

        compareOn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
